// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: consumes the EX/MEM bundle, performs the data-RAM
// access with a fixed multi-cycle latency, and holds the MEM/WB pipeline register.
// StallM holds the upstream stages while a load or store is still in flight.
module mem_access_stage #(
    parameter int unsigned size      = 31,
    parameter int unsigned ADDR_BITS = 6,
    parameter int unsigned MEM_LAT   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RegWriteM,
    input  logic            MemtoRegM,
    input  logic            MemWriteM,
    input  logic [size:0]   ALUOutM,
    input  logic [size:0]   WriteDataM,
    input  logic [4:0]      WriteRegM,
    output logic            StallM,
    output logic            RegWriteW,
    output logic            MemtoRegW,
    output logic [size:0]   ReadDataW,
    output logic [size:0]   ALUOutW,
    output logic [4:0]      WriteRegW,
    output logic [size:0]   ResultW
);

    localparam int unsigned Depth   = 2 ** ADDR_BITS;
    localparam logic [3:0]  LastCnt = 4'(MEM_LAT - 1);

    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 mem_op;
    logic                 is_store;
    logic                 is_load;
    logic                 load_w;
    logic                 retire;
    logic [ADDR_BITS-1:0] word_addr;
    logic [size:0]        ram [Depth];

    // A load+store combination behaves as a store.
    assign mem_op    = MemtoRegM | MemWriteM;
    assign is_store  = MemWriteM;
    assign is_load   = MemtoRegM & ~MemWriteM;
    // Byte offset and bits above the RAM depth are dropped, so addresses wrap.
    assign word_addr = ALUOutM[ADDR_BITS+1:2];

    // Next state, stall request and W-register load decision
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        StallM  = 1'b0;
        load_w  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_op && (MEM_LAT > 1)) begin
                    StallM  = 1'b1;
                    state_d = StAccess;
                    cnt_d   = 4'd1;
                end else begin
                    load_w = 1'b1;
                end
            end
            StAccess: begin
                if (cnt_q < LastCnt) begin
                    StallM = 1'b1;
                    cnt_d  = cnt_q + 4'd1;
                end else begin
                    load_w  = 1'b1;
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
        // Nothing is in flight while reset is held.
        if (!rst_n) begin
            StallM = 1'b0;
        end
    end

    // The single edge on which a memory op takes effect.
    assign retire = load_w & mem_op;

    // FSM state and latency counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Data RAM: a store commits only on its retire edge, never during stalls
    always_ff @(posedge clk) begin
        if (rst_n && retire && is_store) begin
            ram[word_addr] <= WriteDataM;
        end
    end

    // MEM/WB register: bundle on retire or ALU op, bubble while stalling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            ReadDataW <= '0;
            ALUOutW   <= '0;
            WriteRegW <= 5'd0;
        end else if (load_w) begin
            RegWriteW <= RegWriteM;
            MemtoRegW <= MemtoRegM;
            ALUOutW   <= ALUOutM;
            WriteRegW <= WriteRegM;
            // Read sees the pre-write contents of this edge.
            if (retire && is_load) begin
                ReadDataW <= ram[word_addr];
            end
        end else begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
        end
    end

    assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: four instances with MEM_LAT = 1..4 run the same directed
// sequence then random traffic. An op-level reference model pushes the expected
// per-cycle stage view into one queue per instance; a monitor pops and compares.
module tb_mem_access_stage;

    localparam int NL    = 4;
    localparam int NRAND = 150;
    localparam int DEPTH = 64;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic        mw;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  wr;
        logic        abort;
    } op_t;

    typedef struct packed {
        logic        stall;
        logic        rw;
        logic        m2r;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic [31:0] res;
    } obs_t;

    logic          clk = 1'b0;
    logic [NL-1:0] rst_v;
    logic [NL-1:0] rw_v;
    logic [NL-1:0] m2r_v;
    logic [NL-1:0] mw_v;
    logic [31:0]   alu_m [NL];
    logic [31:0]   wd_m  [NL];
    logic [4:0]    wr_m  [NL];
    logic          stall_o [NL];
    logic          rww_o   [NL];
    logic          m2rw_o  [NL];
    logic [31:0]   rd_o    [NL];
    logic [31:0]   aluw_o  [NL];
    logic [4:0]    wrw_o   [NL];
    logic [31:0]   res_o   [NL];

    // Reference model state, one lane per instance
    op_t         plan_q [NL][$];
    obs_t        exp_q  [NL][$];
    logic [31:0] ram_m  [NL][DEPTH];
    obs_t        w_m    [NL];
    op_t         cur    [NL];
    int          cyc    [NL];
    int          lat    [NL];
    bit          busy   [NL];
    int          issued [NL];
    logic [NL-1:0] abort_mask;
    bit          running = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : g_lane
        mem_access_stage #(
            .size      (31),
            .ADDR_BITS (6),
            .MEM_LAT   (g + 1)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_v[g]),
            .RegWriteM  (rw_v[g]),
            .MemtoRegM  (m2r_v[g]),
            .MemWriteM  (mw_v[g]),
            .ALUOutM    (alu_m[g]),
            .WriteDataM (wd_m[g]),
            .WriteRegM  (wr_m[g]),
            .StallM     (stall_o[g]),
            .RegWriteW  (rww_o[g]),
            .MemtoRegW  (m2rw_o[g]),
            .ReadDataW  (rd_o[g]),
            .ALUOutW    (aluw_o[g]),
            .WriteRegW  (wrw_o[g]),
            .ResultW    (res_o[g])
        );
    end

    function automatic op_t mk_op(input logic rw, input logic m2r, input logic mw,
                                  input logic [31:0] alu, input logic [31:0] wd,
                                  input logic [4:0] wr, input logic abort);
        op_t o;
        o.rw    = rw;
        o.m2r   = m2r;
        o.mw    = mw;
        o.alu   = alu;
        o.wd    = wd;
        o.wr    = wr;
        o.abort = abort;
        return o;
    endfunction

    function automatic op_t rand_op();
        int kind;
        kind = $urandom_range(0, 3);
        return mk_op(1'($urandom), (kind == 1) || (kind == 3), kind >= 2,
                     $urandom, $urandom, 5'($urandom), 1'b0);
    endfunction

    // Stage view as seen during a cycle: W outputs plus this cycle's stall.
    function automatic obs_t snap(input obs_t w, input logic stall);
        obs_t r;
        r       = w;
        r.stall = stall;
        r.res   = w.m2r ? w.rd : w.alu;
        return r;
    endfunction

    task automatic drive(input int l, input op_t o);
        rw_v[l]  = o.rw;
        m2r_v[l] = o.m2r;
        mw_v[l]  = o.mw;
        alu_m[l] = o.alu;
        wd_m[l]  = o.wd;
        wr_m[l]  = o.wr;
    endtask

    // One cycle of one lane: a memory op occupies the stage for MEM_LAT cycles,
    // the first MEM_LAT-1 of them stalling with bubbles, and takes effect at the end.
    task automatic step_lane(input int l);
        int         k;
        logic       stall;
        logic [5:0] a;
        if (!busy[l]) begin
            if (plan_q[l].size() > 0) begin
                cur[l] = plan_q[l].pop_front();
            end else if (issued[l] < NRAND) begin
                cur[l] = rand_op();
                issued[l]++;
            end else begin
                cur[l] = '0;
            end
            busy[l] = 1'b1;
            cyc[l]  = 0;
            lat[l]  = (cur[l].m2r || cur[l].mw) ? l + 1 : 1;
        end
        drive(l, cur[l]);
        k = (lat[l] > 1) ? 1 : 0;
        if (cur[l].abort && (cyc[l] == k)) begin
            // Reset is pulsed during this cycle: everything clears, nothing commits.
            w_m[l] = '0;
            exp_q[l].push_back(snap(w_m[l], 1'b0));
            busy[l] = 1'b0;
            abort_mask[l] = 1'b1;
            return;
        end
        stall = (cyc[l] < lat[l] - 1);
        exp_q[l].push_back(snap(w_m[l], stall));
        if (stall) begin
            w_m[l].rw  = 1'b0;
            w_m[l].m2r = 1'b0;
            cyc[l]++;
        end else begin
            a = cur[l].alu[7:2];
            if (cur[l].mw) begin
                ram_m[l][a] = cur[l].wd;
            end else if (cur[l].m2r) begin
                w_m[l].rd = ram_m[l][a];
            end
            w_m[l].rw  = cur[l].rw;
            w_m[l].m2r = cur[l].m2r;
            w_m[l].alu = cur[l].alu;
            w_m[l].wr  = cur[l].wr;
            busy[l] = 1'b0;
        end
    endtask

    task automatic build_plan(input int l);
        plan_q[l].push_back(mk_op(1, 0, 0, 32'h5, 32'h0, 5'd3, 0));
        plan_q[l].push_back(mk_op(0, 0, 1, 32'h10, 32'hDEADBEEF, 5'd0, 0));
        plan_q[l].push_back(mk_op(1, 1, 0, 32'h10, 32'h0, 5'd8, 0));
        plan_q[l].push_back(mk_op(0, 0, 1, 32'h103, 32'h1234, 5'd0, 0));
        plan_q[l].push_back(mk_op(1, 1, 0, 32'h0, 32'h0, 5'd9, 0));
        plan_q[l].push_back(mk_op(0, 0, 1, 32'h1C, 32'hAAAA, 5'd0, 0));
        plan_q[l].push_back(mk_op(0, 0, 1, 32'h1C, 32'h5555, 5'd0, 1));
        plan_q[l].push_back(mk_op(1, 1, 0, 32'h1C, 32'h0, 5'd10, 0));
        plan_q[l].push_back(mk_op(0, 0, 1, 32'h4, 32'h11, 5'd0, 0));
        plan_q[l].push_back(mk_op(0, 0, 1, 32'h8, 32'h22, 5'd0, 0));
        plan_q[l].push_back(mk_op(1, 1, 0, 32'h4, 32'h0, 5'd1, 0));
        plan_q[l].push_back(mk_op(1, 1, 0, 32'h8, 32'h0, 5'd2, 0));
        plan_q[l].push_back(mk_op(1, 1, 1, 32'h8, 32'h33, 5'd4, 0));
        plan_q[l].push_back(mk_op(1, 1, 0, 32'h8, 32'h0, 5'd5, 0));
        // Fill the whole RAM (with junk in the ignored address bits) before random traffic.
        for (int i = 0; i < DEPTH; i++) begin
            plan_q[l].push_back(mk_op(1'($urandom), 0, 1,
                                      {24'($urandom), 6'(i), 2'($urandom)},
                                      $urandom, 5'($urandom), 0));
        end
    endtask

    // Stimulus and reference model
    initial begin
        bit any;
        rst_v = '0;
        for (int l = 0; l < NL; l++) begin
            w_m[l]    = '0;
            busy[l]   = 1'b0;
            issued[l] = 0;
            build_plan(l);
            // A store held on the inputs during reset must neither stall nor commit.
            drive(l, mk_op(0, 0, 1, 32'hC, 32'hBAD, 5'd0, 0));
            exp_q[l].push_back(snap(w_m[l], 1'b0));
        end
        #1 running = 1'b1;
        #11;
        rst_v = '1;
        for (int l = 0; l < NL; l++) drive(l, '0);
        while (1) begin
            @(posedge clk);
            #1;
            any = 1'b0;
            for (int l = 0; l < NL; l++) begin
                if (busy[l] || (plan_q[l].size() > 0) || (issued[l] < NRAND)) any = 1'b1;
            end
            if (!any) break;
            abort_mask = '0;
            for (int l = 0; l < NL; l++) step_lane(l);
            if (abort_mask != '0) begin
                #2 rst_v = rst_v & ~abort_mask;
                #4;
                for (int l = 0; l < NL; l++) begin
                    if (abort_mask[l]) drive(l, '0);
                end
                rst_v = '1;
            end
        end
        running = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Monitor: every lane presents one stage view per cycle, checked mid-cycle
    always @(negedge clk) begin : monitor
        obs_t act;
        obs_t e;
        if (running) begin
            for (int l = 0; l < NL; l++) begin
                act.stall = stall_o[l];
                act.rw    = rww_o[l];
                act.m2r   = m2rw_o[l];
                act.rd    = rd_o[l];
                act.alu   = aluw_o[l];
                act.wr    = wrw_o[l];
                act.res   = res_o[l];
                n_checks++;
                if (exp_q[l].size() == 0) begin
                    n_fail++;
                    $display("FAIL lat%0d t=%0t stage_view: no expected entry", l + 1, $time);
                end else begin
                    e = exp_q[l].pop_front();
                    if (act !== e) begin
                        n_fail++;
                        $display({"FAIL lat%0d t=%0t stage_view: got stall=%b rw=%b m2r=%b ",
                                  "rd=%h alu=%h wr=%0d res=%h, expected stall=%b rw=%b m2r=%b ",
                                  "rd=%h alu=%h wr=%0d res=%h"}, l + 1, $time,
                                 act.stall, act.rw, act.m2r, act.rd, act.alu, act.wr, act.res,
                                 e.stall, e.rw, e.m2r, e.rd, e.alu, e.wr, e.res);
                    end
                end
            end
        end
    end

endmodule
